// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared op encodings, snapshot states and default sizing for the register file pair.
package reg_file_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 12;
  localparam int DUMP_BITS = DEF_DEPTH * DEF_WIDTH;
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_INC2 = 2'b11;
  typedef enum logic {SNAP_IDLE, SNAP_SHIFT} snap_state_e;
endpackage

// File: rtl/reg_file_pair_shifter.sv
// reg_snapshot_shifter: captures all registers on request and streams them out MSB first, reg 0 first.
module reg_snapshot_shifter import reg_file_pkg::*; #(
  parameter int NBITS = DUMP_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             snap_req_i,
  input  logic [NBITS-1:0] regs_i,
  output logic             snap_busy_o,
  output logic             snap_start_o,
  output logic             snap_valid_o,
  output logic             serial_o
);
  localparam int CW = $clog2(NBITS);
  snap_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NBITS-1:0] shadow_q, shadow_d;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    if (state_q == SNAP_IDLE) begin
      if (snap_req_i) begin
        shadow_d = regs_i;
        cnt_d    = '0;
        state_d  = SNAP_SHIFT;
      end
    end else begin
      shadow_d = shadow_q << 1;
      cnt_d    = cnt_q + 1'b1;
      state_d  = (cnt_q == CW'(NBITS - 1)) ? SNAP_IDLE : SNAP_SHIFT;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SNAP_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end
  assign snap_busy_o  = state_q == SNAP_SHIFT;
  assign snap_valid_o = snap_busy_o;
  assign snap_start_o = snap_busy_o && cnt_q == '0;
  assign serial_o     = snap_busy_o && shadow_q[NBITS-1];
endmodule

// File: rtl/reg_file_pair.sv
// reg_file_pair: byte/pair register file with pair inc/dec, two read ports, optional bypass and serial dump.
module reg_file_pair import reg_file_pkg::*; #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int SEL_W  = $clog2(DEPTH),
  parameter bit BYPASS = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SEL_W:0]     rd_a_sel,
  input  logic [SEL_W:0]     rd_b_sel,
  input  logic [SEL_W:0]     wr_sel,
  input  logic [1:0]         op,
  input  logic               we,
  input  logic [2*WIDTH-1:0] data_in,
  output logic [2*WIDTH-1:0] rd_a_data,
  output logic [2*WIDTH-1:0] rd_b_data,
  output logic               wrap,
  input  logic               snap_req,
  output logic               snap_busy,
  output logic               snap_start,
  output logic               snap_valid,
  output logic               serial_out
);
  localparam int PW = 2 * WIDTH;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH*WIDTH-1:0] cur_flat, rd_flat, dump_flat;
  logic [SEL_W-1:0] wr_base;
  logic [PW-1:0] cur_pair;
  logic [PW:0] op_res;
  logic op_act, op_ok, we_ok, wr_fwd, wrap_q, wrap_d;
  function automatic logic [SEL_W-1:0] base_of(input logic [SEL_W:0] s);
    return s[SEL_W-1:0] & ~SEL_W'(1);
  endfunction
  function automatic logic ok_of(input logic [SEL_W:0] s);
    return s[SEL_W] ? int'(base_of(s)) + 1 < DEPTH : int'(s[SEL_W-1:0]) < DEPTH;
  endfunction
  // Out-of-range selections read as zero rather than aliasing.
  function automatic logic [PW-1:0] rd(input logic [SEL_W:0] s, input logic [DEPTH*WIDTH-1:0] v);
    if (!ok_of(s)) return '0;
    return s[SEL_W] ? {v[int'(base_of(s))*WIDTH +: WIDTH], v[(int'(base_of(s))+1)*WIDTH +: WIDTH]}
                    : {{WIDTH{1'b0}}, v[int'(s[SEL_W-1:0])*WIDTH +: WIDTH]};
  endfunction
  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign cur_flat[g*WIDTH +: WIDTH]             = regs_q[g];
    assign rd_flat[g*WIDTH +: WIDTH]              = wr_fwd ? regs_d[g] : regs_q[g];
    assign dump_flat[(DEPTH-1-g)*WIDTH +: WIDTH] = regs_q[g];
  end
  assign op_act   = op != OP_NONE;
  assign op_ok    = ok_of({1'b1, wr_sel[SEL_W-1:0]});
  assign we_ok    = ok_of(wr_sel);
  assign wr_base  = base_of(wr_sel);
  assign wr_fwd   = BYPASS && !op_act && we;
  assign cur_pair = rd({1'b1, wr_sel[SEL_W-1:0]}, cur_flat);
  // The extra top bit of op_res is the carry/borrow that drives wrap.
  assign op_res = (op == OP_DEC) ? {1'b0, cur_pair} - 1'b1
                                 : {1'b0, cur_pair} + ((op == OP_INC2) ? (PW+1)'(2) : (PW+1)'(1));
  always_comb begin
    regs_d = regs_q;
    wrap_d = 1'b0;
    if (op_act && op_ok) begin
      regs_d[wr_base]        = op_res[PW-1:WIDTH];
      regs_d[wr_base + 1'b1] = op_res[WIDTH-1:0];
      wrap_d                 = op_res[PW];
    end else if (!op_act && we && we_ok) begin
      if (wr_sel[SEL_W]) begin
        regs_d[wr_base]        = data_in[PW-1:WIDTH];
        regs_d[wr_base + 1'b1] = data_in[WIDTH-1:0];
      end else begin
        regs_d[wr_sel[SEL_W-1:0]] = data_in[WIDTH-1:0];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      wrap_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      wrap_q <= wrap_d;
    end
  end
  assign rd_a_data = rd(rd_a_sel, rd_flat);
  assign rd_b_data = rd(rd_b_sel, rd_flat);
  assign wrap      = wrap_q;
  reg_snapshot_shifter #(.NBITS(DEPTH * WIDTH)) u_snap (
    .clk          (clk),
    .rst          (rst),
    .snap_req_i   (snap_req),
    .regs_i       (dump_flat),
    .snap_busy_o  (snap_busy),
    .snap_start_o (snap_start),
    .snap_valid_o (snap_valid),
    .serial_o     (serial_out)
  );
endmodule

// File: tb/tb_reg_file_pair.sv
// tb_reg_file_pair: random and directed checks of both bypass variants against a cycle model.
module tb_reg_file_pair;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] rd_a_sel = '0, rd_b_sel = '0, wr_sel = '0;
  logic [1:0] op = '0;
  logic we = 1'b0, snap_req = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] a0, b0, a1, b1;
  logic wrap0, wrap1, busy0, busy1, start0, start1, valid0, valid1, ser0, ser1;
  int checks = 0, failures = 0;
  int m[12];
  bit mwrap = 0, mbusy = 0;
  int msent = 0;
  bit mq[$];
  always #5 clk = ~clk;
  reg_file_pair #(.BYPASS(1'b0)) dut (
    .clk(clk), .rst(rst), .rd_a_sel(rd_a_sel), .rd_b_sel(rd_b_sel), .wr_sel(wr_sel), .op(op), .we(we),
    .data_in(data_in), .rd_a_data(a0), .rd_b_data(b0), .wrap(wrap0), .snap_req(snap_req),
    .snap_busy(busy0), .snap_start(start0), .snap_valid(valid0), .serial_out(ser0));
  reg_file_pair #(.BYPASS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .rd_a_sel(rd_a_sel), .rd_b_sel(rd_b_sel), .wr_sel(wr_sel), .op(op), .we(we),
    .data_in(data_in), .rd_a_data(a1), .rd_b_data(b1), .wrap(wrap1), .snap_req(snap_req),
    .snap_busy(busy1), .snap_start(start1), .snap_valid(valid1), .serial_out(ser1));
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] exp_rd(input logic [4:0] s, input bit byp);
    int v[12];
    int idx, b, wb;
    v = m;
    idx = int'(s[3:0]);
    b = idx & ~1;
    wb = int'(wr_sel[3:0]) & ~1;
    if (byp && we && op == 2'b00) begin
      if (wr_sel[4]) begin
        if (wb + 1 < 12) begin
          v[wb] = int'(data_in[15:8]);
          v[wb+1] = int'(data_in[7:0]);
        end
      end else if (int'(wr_sel[3:0]) < 12) v[int'(wr_sel[3:0])] = int'(data_in[7:0]);
    end
    if (s[4]) return (b + 1 < 12) ? 16'(v[b] * 256 + v[b+1]) : 16'h0;
    return (idx < 12) ? 16'(v[idx]) : 16'h0;
  endfunction
  // Advances the model by the edge that follows, using the inputs held through it.
  function automatic void step();
    int b, val;
    if (rst) begin
      foreach (m[i]) m[i] = 0;
      mwrap = 0;
      mbusy = 0;
      msent = 0;
      mq.delete();
      return;
    end
    if (mbusy) begin
      void'(mq.pop_front());
      msent++;
      if (mq.size() == 0) mbusy = 0;
    end else if (snap_req) begin
      for (int r = 0; r < 12; r++)
        for (int k = 7; k >= 0; k--) mq.push_back(bit'((m[r] >> k) & 1));
      mbusy = 1;
      msent = 0;
    end
    mwrap = 0;
    b = int'(wr_sel[3:0]) & ~1;
    if (op != 2'b00) begin
      if (b + 1 < 12) begin
        val = m[b] * 256 + m[b+1] + ((op == 2'b01) ? 1 : (op == 2'b11) ? 2 : -1);
        mwrap = val < 0 || val > 65535;
        val = val & 65535;
        m[b] = val >> 8;
        m[b+1] = val & 255;
      end
    end else if (we) begin
      if (wr_sel[4]) begin
        if (b + 1 < 12) begin
          m[b] = int'(data_in[15:8]);
          m[b+1] = int'(data_in[7:0]);
        end
      end else if (int'(wr_sel[3:0]) < 12) m[int'(wr_sel[3:0])] = int'(data_in[7:0]);
    end
  endfunction
  always @(negedge clk) begin
    check("rd_a_nobyp", a0, exp_rd(rd_a_sel, 0));
    check("rd_b_nobyp", b0, exp_rd(rd_b_sel, 0));
    check("rd_a_byp", a1, exp_rd(rd_a_sel, 1));
    check("rd_b_byp", b1, exp_rd(rd_b_sel, 1));
    check("wrap", {wrap0, wrap1}, {mwrap, mwrap});
    check("snap_busy", {busy0, busy1}, {mbusy, mbusy});
    check("snap_valid", {valid0, valid1}, {mbusy, mbusy});
    check("snap_start", {start0, start1}, {2{mbusy && msent == 0}});
    check("serial_out", {ser0, ser1}, {2{mbusy ? mq[0] : 1'b0}});
    step();
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [95:0] got;
    int starts, nvalid;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_a_sel = 5'b10000;
    rd_b_sel = 5'b11010;
    @(negedge clk);
    check("t1_pair0", a0, 16'h0000);
    check("t1_pair10", b1, 16'h0000);
    check("t1_wrap", wrap0, 1'b0);
    check("t1_busy", busy0, 1'b0);
    tick();
    wr_sel = 5'b10100; we = 1'b1; data_in = 16'h12FF;
    tick();
    we = 1'b0; op = 2'b01;
    tick();
    op = 2'b00; rd_a_sel = 5'b10100;
    @(negedge clk);
    check("t2_inc", a0, 16'h1300);
    check("t2_nowrap", wrap0, 1'b0);
    tick();
    we = 1'b1; data_in = 16'hFFFF;
    tick();
    we = 1'b0; op = 2'b01;
    tick();
    op = 2'b00;
    @(negedge clk);
    check("t2_inc_wrapval", a0, 16'h0000);
    check("t2_wrap", {wrap0, wrap1}, 2'b11);
    tick();
    @(negedge clk);
    check("t2_wrap_pulse", wrap0, 1'b0);
    tick();
    wr_sel = 5'b00011; we = 1'b1; data_in = 16'h00A5; rd_a_sel = 5'b00011;
    @(negedge clk);
    check("t3_bypass", a1, 16'h00A5);
    check("t3_nobypass_old", a0, 16'h0000);
    tick();
    we = 1'b0;
    @(negedge clk);
    check("t3_after_edge", a0, 16'h00A5);
    tick();
    wr_sel = 5'b10000; we = 1'b1; data_in = 16'h1234; op = 2'b10; rd_a_sel = 5'b10000;
    @(negedge clk);
    check("t4_op_not_forwarded", a1, 16'h0000);
    tick();
    we = 1'b0; op = 2'b00;
    @(negedge clk);
    check("t4_dec", a0, 16'hFFFF);
    check("t4_wrap", wrap0, 1'b1);
    tick();
    for (int i = 0; i < 12; i++) begin
      wr_sel = {1'b0, 4'(i)}; we = 1'b1; data_in = 16'(i + 1);
      tick();
    end
    we = 1'b0; snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    got = '0; starts = 0; nvalid = 0;
    for (int k = 0; k < 96; k++) begin
      @(negedge clk);
      got = {got[94:0], ser0};
      starts += int'(start0);
      nvalid += int'(valid0);
      if (k == 0) check("t5_start_bit0", start0, 1'b1);
    end
    check("t5_stream", got, 96'h0102030405060708090A0B0C);
    check("t5_starts", starts, 1);
    check("t5_valid_bits", nvalid, 96);
    @(negedge clk);
    check("t5_idle_after", busy0, 1'b0);
    tick();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    repeat (40) tick();
    rst = 1'b1; wr_sel = 5'b01100; we = 1'b1; data_in = 16'h00EE;
    tick();
    rst = 1'b0; rd_b_sel = 5'b01100;
    @(negedge clk);
    check("t6_abort", {busy0, valid0, ser0}, 3'b000);
    check("t6_idx12", b0, 16'h0000);
    tick();
    we = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      rst = $urandom_range(0, 399) == 0;
      rd_a_sel = 5'($urandom);
      rd_b_sel = 5'($urandom);
      wr_sel = 5'($urandom);
      op = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      we = 1'($urandom);
      data_in = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'hFFFE) : 16'($urandom);
      snap_req = $urandom_range(0, 29) == 0;
      tick();
    end
    rst = 1'b0; we = 1'b0; op = 2'b00; snap_req = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
